io_sys_update_seq: RTL and testbench

- IO-mapped remote-system-update sequencer; the next generation of the flash-specific update peripherals, generic over the flash/RSU IP.
- Exposes an RSU-IP-side port instead of instantiating a part-specific IP; data width is parametrised.
- Sequences write_param/read_param handshakes with busy tracking and timeout, latches read results into a shadow register, guards reconfig behind an unlock key, and runs a programmable watchdog kicker.

---
 rtl/io_sys_update_seq_if.sv | 36 +++
 rtl/io_sys_update_seq.sv | 176 +++++++++++++++++
 tb/tb_io_sys_update_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/io_sys_update_seq_if.sv
// IO-side and RSU-IP-side signal bundle for the update sequencer.
// slave = sequencer side, master = IO master / RSU IP side.
interface io_sys_update_seq_if #(
    parameter int CDataW = 32
);
    logic [15:0]       AIoAddr;
    logic [63:0]       AIoMiso;
    logic [63:0]       AIoMosi;
    logic [3:0]        AIoWrSize;
    logic [3:0]        AIoRdSize;
    logic              AIoAddrAck;
    logic              AIoAddrErr;
    logic              AIoBusy;
    logic [2:0]        ARsuParam;
    logic [1:0]        ARsuSource;
    logic [CDataW-1:0] ARsuDataIn;
    logic              ARsuWrite;
    logic              ARsuRead;
    logic              ARsuReconfig;
    logic              ARsuResetTimer;
    logic [CDataW-1:0] ARsuDataOut;
    logic              ARsuBusy;
    logic [7:0]        ATest;

    modport slave (
        input  AIoAddr, AIoMosi, AIoWrSize, AIoRdSize, ARsuDataOut, ARsuBusy,
        output AIoMiso, AIoAddrAck, AIoAddrErr, AIoBusy, ARsuParam, ARsuSource,
               ARsuDataIn, ARsuWrite, ARsuRead, ARsuReconfig, ARsuResetTimer, ATest
    );

    modport master (
        output AIoAddr, AIoMosi, AIoWrSize, AIoRdSize, ARsuDataOut, ARsuBusy,
        input  AIoMiso, AIoAddrAck, AIoAddrErr, AIoBusy, ARsuParam, ARsuSource,
               ARsuDataIn, ARsuWrite, ARsuRead, ARsuReconfig, ARsuResetTimer, ATest
    );
endinterface

// File: rtl/io_sys_update_seq.sv
// IO-mapped remote-system-update sequencer: param read/write handshakes with timeout,
// key-guarded reconfig and a programmable watchdog kicker. IO reads are combinational.
module io_sys_update_seq #(
    parameter logic [15:0] CAddrBase = 16'h0000,
    parameter int          CDataW    = 32,
    parameter int          CTimeout  = 4096,
    parameter int          CWdtW     = 16
) (
    input logic               AClkH,
    input logic               AResetH,
    input logic               AClkHEn,
    io_sys_update_seq_if.slave io
);
    localparam int CTW = (CTimeout > 2) ? $clog2(CTimeout) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RCFG = 3'd3;

    logic [2:0]        state;
    logic              op_rd;
    logic [CTW-1:0]    wait_cnt;
    logic [CDataW-1:0] data_in;
    logic [CDataW-1:0] shadow;
    logic [4:0]        addr_reg;
    logic [CWdtW-1:0]  wdt_period;
    logic [CWdtW-1:0]  wdt_cnt;
    logic              err, rdv, key, wdten;

    logic [15:0] off;
    logic        in_range, has_wr, has_rd, legal;
    logic [63:0] rd_dat;
    logic        ack, busy_st, io_busy;
    logic        wr_ctrl, wr_key, wr_addr, wr_op, rd_op, wr_wdt, rcfg_req, is_cmd;
    logic        wdt_on;
    logic        unused_mosi;

    assign off      = io.AIoAddr - CAddrBase;
    assign in_range = (off < 16'd8);
    assign has_wr   = (io.AIoWrSize != 4'd0);
    assign has_rd   = (io.AIoRdSize != 4'd0);
    assign busy_st  = (state != S_IDLE);

    // Only one direction per access; anything else in the window is an address error.
    always_comb begin
        legal  = 1'b0;
        rd_dat = 64'd0;
        case (off[2:0])
            3'd0: begin
                if (io.AIoWrSize == 4'd1 && !has_rd) legal = 1'b1;
                else if (io.AIoRdSize == 4'd1 && !has_wr) begin
                    legal  = 1'b1;
                    rd_dat = 64'({3'b000, wdten, key, err, rdv, busy_st});
                end
            end
            3'd1: legal = (io.AIoWrSize == 4'd1) && !has_rd;
            3'd2: begin
                if ((io.AIoWrSize == 4'd1 || io.AIoWrSize == 4'd4) && !has_rd) legal = 1'b1;
                else if (io.AIoRdSize == 4'd1 && !has_wr) begin
                    legal  = 1'b1;
                    rd_dat = 64'(addr_reg);
                end else if (io.AIoRdSize == 4'd4 && !has_wr) begin
                    legal  = 1'b1;
                    rd_dat = 64'(shadow);
                end
            end
            3'd4: legal = (io.AIoWrSize == 4'd1) && !has_rd;
            3'd6: begin
                if (io.AIoWrSize == 4'd2 && !has_rd) legal = 1'b1;
                else if (io.AIoRdSize == 4'd2 && !has_wr) begin
                    legal  = 1'b1;
                    rd_dat = 64'(wdt_period);
                end
            end
            default: legal = 1'b0;
        endcase
    end

    assign ack      = in_range && legal;
    assign wr_ctrl  = ack && has_wr && (off[2:0] == 3'd0);
    assign wr_key   = ack && has_wr && (off[2:0] == 3'd1);
    assign wr_addr  = ack && (off[2:0] == 3'd2) && (io.AIoWrSize == 4'd1);
    assign wr_op    = ack && (off[2:0] == 3'd2) && (io.AIoWrSize == 4'd4);
    assign rd_op    = ack && has_wr && (off[2:0] == 3'd4);
    assign wr_wdt   = ack && has_wr && (off[2:0] == 3'd6);
    assign rcfg_req = wr_ctrl && io.AIoMosi[0] && key;
    assign is_cmd   = wr_op || rd_op || rcfg_req;
    assign io_busy  = is_cmd && busy_st;
    assign wdt_on   = wdten && (wdt_period != '0);

    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            state    <= S_IDLE;
            op_rd    <= 1'b0;
            wait_cnt <= '0;
            data_in  <= '0;
            shadow   <= '0;
            addr_reg <= '0;
            wdt_period <= '0;
            err      <= 1'b0;
            rdv      <= 1'b0;
            key      <= 1'b0;
            wdten    <= 1'b0;
        end else if (AClkHEn) begin
            if (!io_busy) begin
                if (wr_ctrl) begin
                    key   <= 1'b0;
                    wdten <= io.AIoMosi[1];
                    if (io.AIoMosi[2]) err <= 1'b0;
                    if (io.AIoMosi[0] && !key) err <= 1'b1;
                    if (rcfg_req) state <= S_RCFG;
                end
                if (wr_key)  key        <= (io.AIoMosi[7:0] == 8'hA5);
                if (wr_addr) addr_reg   <= io.AIoMosi[4:0];
                if (wr_wdt)  wdt_period <= io.AIoMosi[CWdtW-1:0];
                if (wr_op) begin
                    data_in <= io.AIoMosi[CDataW-1:0];
                    op_rd   <= 1'b0;
                    state   <= S_REQ;
                end
                if (rd_op) begin
                    op_rd <= 1'b1;
                    rdv   <= 1'b0;
                    state <= S_REQ;
                end
            end
            // Commands are only accepted in IDLE, so they never collide with these transitions.
            case (state)
                S_REQ: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (!io.ARsuBusy && wait_cnt != '0) begin
                        state <= S_IDLE;
                        if (op_rd) begin
                            shadow <= io.ARsuDataOut;
                            rdv    <= 1'b1;
                        end
                    end else if (wait_cnt == CTW'(CTimeout - 1)) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            wdt_cnt <= '0;
        end else if (AClkHEn) begin
            if (wr_wdt || !wdt_on || wdt_cnt == wdt_period) wdt_cnt <= '0;
            else                                             wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    assign io.AIoAddrAck     = ack;
    assign io.AIoAddrErr     = in_range && (has_wr || has_rd) && !legal;
    assign io.AIoMiso        = ack ? rd_dat : 64'd0;
    assign io.AIoBusy        = io_busy;
    assign io.ARsuParam      = addr_reg[2:0];
    assign io.ARsuSource     = addr_reg[4:3];
    assign io.ARsuDataIn     = data_in;
    assign io.ARsuWrite      = (state == S_REQ) && !op_rd;
    assign io.ARsuRead       = (state == S_REQ) && op_rd;
    assign io.ARsuReconfig   = (state == S_RCFG);
    assign io.ARsuResetTimer = wdt_on && (wdt_cnt == wdt_period);
    assign io.ATest          = {io_busy, state, err, rdv, key, wdten};

    assign unused_mosi = ^io.AIoMosi;
endmodule

// File: tb/tb_io_sys_update_seq.sv
// Directed bench for io_sys_update_seq: register map, op sequencing, timeout, reconfig, watchdog.
module tb_io_sys_update_seq;
    logic AClkH = 1'b0;
    logic AResetH;
    logic AClkHEn;
    int   total = 0;
    int   bad   = 0;

    io_sys_update_seq_if #(.CDataW(32)) bus ();

    io_sys_update_seq #(
        .CAddrBase(16'h0000), .CDataW(32), .CTimeout(4096), .CWdtW(16)
    ) dut (
        .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn), .io(bus)
    );

    always #5 AClkH = ~AClkH;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [3:0] sz, input logic [63:0] d);
        bus.AIoAddr   = a;
        bus.AIoMosi   = d;
        bus.AIoWrSize = sz;
        bus.AIoRdSize = 4'd0;
        @(posedge AClkH);
        #1;
        bus.AIoWrSize = 4'd0;
        bus.AIoMosi   = 64'd0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [3:0] sz, output logic [63:0] d);
        bus.AIoAddr   = a;
        bus.AIoWrSize = 4'd0;
        bus.AIoRdSize = sz;
        #1;
        d = bus.AIoMiso;
        bus.AIoRdSize = 4'd0;
    endtask

    function automatic logic [63:0] rsu_outs();
        return 64'({bus.ARsuParam, bus.ARsuSource, bus.ARsuDataIn, bus.ARsuWrite,
                    bus.ARsuRead, bus.ARsuReconfig, bus.ARsuResetTimer, bus.ATest});
    endfunction

    initial begin
        logic [63:0] d;
        int busy_cyc, wp, rp, seen, n, first, last;

        AResetH = 1'b1;
        AClkHEn = 1'b1;
        bus.AIoAddr = 16'd0; bus.AIoMosi = 64'd0;
        bus.AIoWrSize = 4'd0; bus.AIoRdSize = 4'd0;
        bus.ARsuDataOut = 32'd0; bus.ARsuBusy = 1'b0;
        repeat (2) @(posedge AClkH);
        #1 AResetH = 1'b0;

        rd(16'd0, 4'd1, d); chk("rst_status", d, 64'h00);
        rd(16'd2, 4'd4, d); chk("rst_shadow", d, 64'h0);
        chk("rst_rsu_outs", rsu_outs(), 64'h0);

        AClkHEn = 1'b0;
        wr(16'd2, 4'd1, 64'h1F);
        AClkHEn = 1'b1;
        chk("clken_hold", 64'(bus.ARsuParam), 64'd0);

        wr(16'd2, 4'd1, 64'h0B);
        chk("param", 64'(bus.ARsuParam), 64'd3);
        chk("source", 64'(bus.ARsuSource), 64'd1);
        rd(16'd2, 4'd1, d); chk("addr_readback", d, 64'h0B);

        // Write op: IP busy for 3 cycles starting when WAIT is entered
        wr(16'd2, 4'd4, 64'h00123456);
        busy_cyc = 0; wp = 0;
        bus.AIoAddr = 16'd0; bus.AIoRdSize = 4'd1;
        for (int i = 0; i < 10; i++) begin
            bus.ARsuBusy = (i >= 1 && i <= 3);
            #3;
            busy_cyc += int'(bus.AIoMiso[0]);
            wp += int'(bus.ARsuWrite);
            @(posedge AClkH); #1;
        end
        bus.AIoRdSize = 4'd0; bus.ARsuBusy = 1'b0;
        chk("wr_busy_cycles", 64'(busy_cyc), 64'd5);
        chk("wr_pulses", 64'(wp), 64'd1);
        chk("wr_data_in", 64'(bus.ARsuDataIn), 64'h00123456);

        // Read op with a stalled write command during WAIT
        wr(16'd4, 4'd1, 64'h0);
        rd(16'd0, 4'd1, d); chk("rd_req_status", d, 64'h01);
        rp = 0; wp = 0; seen = 0;
        for (int i = 0; i < 8; i++) begin
            bus.ARsuBusy    = (i >= 1 && i <= 2);
            bus.ARsuDataOut = (i == 3) ? 32'hDEADBEEF : 32'h0;
            if (i == 1) begin
                bus.AIoAddr = 16'd2; bus.AIoWrSize = 4'd4; bus.AIoMosi = 64'hCAFE;
            end else begin
                bus.AIoWrSize = 4'd0;
            end
            #3;
            if (i == 1) seen = int'(bus.AIoBusy);
            rp += int'(bus.ARsuRead);
            wp += int'(bus.ARsuWrite);
            @(posedge AClkH); #1;
        end
        bus.AIoWrSize = 4'd0; bus.ARsuBusy = 1'b0;
        chk("rd_stall_iobusy", 64'(seen), 64'd1);
        chk("rd_pulses", 64'(rp), 64'd1);
        chk("rd_no_wr_pulse", 64'(wp), 64'd0);
        rd(16'd0, 4'd1, d); chk("rd_status", d, 64'h02);
        rd(16'd2, 4'd4, d); chk("rd_shadow", d, 64'hDEADBEEF);
        chk("stalled_data_in", 64'(bus.ARsuDataIn), 64'h00123456);

        // Timeout: busy stuck high
        wr(16'd2, 4'd4, 64'h111);
        bus.ARsuBusy = 1'b1;
        bus.AIoAddr = 16'd0; bus.AIoRdSize = 4'd1;
        for (n = 0; n < 5000; n++) begin
            #3;
            if (!bus.AIoMiso[0]) break;
            @(posedge AClkH); #1;
        end
        bus.AIoRdSize = 4'd0; bus.ARsuBusy = 1'b0;
        @(posedge AClkH); #1;
        chk("timeout_cycles", 64'(n), 64'd4097);
        rd(16'd0, 4'd1, d); chk("timeout_status", d, 64'h06);
        rd(16'd2, 4'd4, d); chk("timeout_shadow", d, 64'hDEADBEEF);
        wr(16'd0, 4'd1, 64'h04);
        rd(16'd0, 4'd1, d); chk("err_clear", d, 64'h02);

        // Illegal accesses
        bus.AIoAddr = 16'd0; bus.AIoWrSize = 4'd2; bus.AIoMosi = 64'h02;
        #1;
        chk("err_word_ctrl", 64'({bus.AIoAddrAck, bus.AIoAddrErr}), 64'b01);
        @(posedge AClkH); #1;
        bus.AIoWrSize = 4'd0;
        rd(16'd0, 4'd1, d); chk("err_no_effect", d, 64'h02);
        bus.AIoAddr = 16'd4; bus.AIoRdSize = 4'd1;
        #1;
        chk("err_read_cmd", 64'({bus.AIoAddrAck, bus.AIoAddrErr}), 64'b01);
        bus.AIoAddr = 16'd8;
        #1;
        chk("out_of_range", 64'({bus.AIoAddrAck, bus.AIoAddrErr, bus.AIoMiso}), 64'h0);
        bus.AIoRdSize = 4'd0;

        // Watchdog
        wr(16'd6, 4'd2, 64'd10);
        rd(16'd6, 4'd2, d); chk("wdt_period", d, 64'd10);
        wr(16'd0, 4'd1, 64'h02);
        n = 0; first = -1; last = -1;
        for (int i = 0; i < 40; i++) begin
            #3;
            if (bus.ARsuResetTimer) begin
                n++;
                if (first < 0) first = i;
                last = i;
            end
            @(posedge AClkH); #1;
        end
        chk("wdt_count", 64'(n), 64'd3);
        chk("wdt_first", 64'(first), 64'd10);
        chk("wdt_last", 64'(last), 64'd32);
        wr(16'd6, 4'd2, 64'd0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            #3;
            n += int'(bus.ARsuResetTimer);
            @(posedge AClkH); #1;
        end
        chk("wdt_off", 64'(n), 64'd0);
        rd(16'd0, 4'd1, d); chk("wdt_status", d, 64'h12);

        // Asynchronous reset in the middle of WAIT
        wr(16'd2, 4'd4, 64'h0ABC);
        bus.ARsuBusy = 1'b1;
        @(posedge AClkH); #1;
        @(posedge AClkH); #1;
        chk("mid_wait_atest", 64'(bus.ATest), 64'h25);
        AResetH = 1'b1;
        #1;
        chk("async_rst_outs", rsu_outs(), 64'h0);
        rd(16'd0, 4'd1, d); chk("async_rst_status", d, 64'h00);
        @(posedge AClkH); #1;
        AResetH = 1'b0;
        bus.ARsuBusy = 1'b0;

        // Reconfig guard
        wr(16'd0, 4'd1, 64'h01);
        chk("rcfg_nokey", 64'(bus.ARsuReconfig), 64'd0);
        rd(16'd0, 4'd1, d); chk("rcfg_nokey_status", d, 64'h04);
        wr(16'd1, 4'd1, 64'hA5);
        rd(16'd0, 4'd1, d); chk("key_armed", d, 64'h0C);
        wr(16'd1, 4'd1, 64'h5A);
        rd(16'd0, 4'd1, d); chk("key_disarmed", d, 64'h04);
        wr(16'd1, 4'd1, 64'hA5);
        wr(16'd0, 4'd1, 64'h05);
        chk("rcfg_on", 64'(bus.ARsuReconfig), 64'd1);
        rd(16'd0, 4'd1, d); chk("rcfg_status", d, 64'h01);
        bus.AIoAddr = 16'd4; bus.AIoWrSize = 4'd1;
        #1;
        chk("rcfg_cmd_stall", 64'(bus.AIoBusy), 64'd1);
        @(posedge AClkH); #1;
        bus.AIoWrSize = 4'd0;
        chk("rcfg_no_read", 64'(bus.ARsuRead), 64'd0);
        repeat (5) @(posedge AClkH);
        #1;
        chk("rcfg_held", 64'({bus.ARsuReconfig, bus.ATest[6:4]}), 64'b1011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
